mig1_fetch_unit: RTL
====================

Name: mig1_fetch_unit

Overview:
- Instruction fetch stage between the Mig1 core's PC/redirect logic and the single-port read side of SimRAM.
- Generates word-aligned sequential fetch addresses and absorbs SimRAM's 1-cycle read latency.
- Buffers fetched words in a small prefetch FIFO and delivers (pc, insn) pairs to decode over a valid/ready handshake.
- Handles branch/debug redirects by flushing buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 8: byte address width; fetch addresses always have [1:0]=2'b00.
- DATA_WIDTH, 32: instruction word width.
- FIFO_DEPTH, 4: prefetch buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rst_addr  in  ADDR_WIDTH-2  boot word address; sampled in BOOT.
- redirect_valid  in  1  load new PC, flush pipeline.
- redirect_addr  in  ADDR_WIDTH-2  redirect word address.
- mem_rd_en  out  1  SimRAM read enable.
- mem_rd_addr  out  ADDR_WIDTH  SimRAM byte address.
- mem_rd_data  in  DATA_WIDTH  SimRAM data; valid the cycle after mem_rd_en.
- insn_valid  out  1  FIFO head valid.
- insn_ready  in  1  decode accepts head.
- insn_data  out  DATA_WIDTH  instruction word at head.
- insn_pc  out  ADDR_WIDTH  byte address of insn_data.

Behaviour:
- Reset (rst_n=0, async):
  - state=BOOT; pc=0; FIFO empty; inflight=0.
  - Outputs: mem_rd_en=0, mem_rd_addr=0, insn_valid=0, insn_data=0, insn_pc=0.
- States:
  - BOOT: one cycle after reset release; pc<={rst_addr,2'b00}; -> FETCH. No read is issued in BOOT.
  - FETCH: normal operation.
  - FLUSH: entered on redirect_valid; one cycle with no issue; -> FETCH.
- Issue rule in FETCH: mem_rd_en=1 iff !redirect_valid and (fifo_count + inflight) < FIFO_DEPTH.
  - The count used is the registered count; a same-cycle pop does not create a credit until the next cycle.
  - On issue: mem_rd_addr=pc; pc<=pc+4 modulo 2^ADDR_WIDTH, so 0xFC wraps to 0x00.
  - mem_rd_en and mem_rd_addr are combinational from state/pc/credits.
- inflight: set on issue; cleared the next cycle when mem_rd_data is captured.
  - Captured data is pushed as {pc_of_request, mem_rd_data}, unless the request was killed.
  - Credit rule guarantees a push never meets a full FIFO; an overflow is an assertion error.
- Handshake:
  - Pop when insn_valid && insn_ready.
  - insn_data and insn_pc are stable while insn_valid=1 and insn_ready=0.
  - insn_valid=1 iff FIFO non-empty; head is registered, with no combinational path from mem_rd_data.
  - Simultaneous push and pop is allowed; count is unchanged.
  - Steady-state throughput is 1 insn/cycle with insn_ready held high.
- Redirect (highest priority, any state except BOOT):
  - FIFO cleared the same edge; insn_valid=0 next cycle.
  - Outstanding read is marked killed and its data dropped.
  - pc<={redirect_addr,2'b00}; state=FLUSH.
  - First read at the new PC issues the cycle after FLUSH.
  - Redirect during FLUSH reloads pc again and stays in FLUSH.
  - Redirect in BOOT is ignored.
- A pop in the same cycle as a redirect is still counted as accepted by decode; the flush wins for FIFO contents.
- Latency: redirect to first insn_valid is 3 cycles (FLUSH, issue, capture).

Optional Feature:
- Macro: MIG1_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (incremented per pop), perf_stall[31:0] (incremented each cycle insn_valid && !insn_ready), and perf_flush[15:0] (incremented per accepted redirect).
  - Counters wrap silently and reset to 0.
- Undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- Package mig1_pkg:
  - Constants: MIG1_ADDR_WIDTH=8, MIG1_DATA_WIDTH=32.
  - Typedefs: mig1_fetch_state_e {BOOT, FETCH, FLUSH}; mig1_fetch_entry_t struct {pc, insn}.
- Sub-module mig1_fetch_fifo:
  - Synchronous FIFO of mig1_fetch_entry_t, FIFO_DEPTH entries.
  - Ports: push, pop, clear, full, empty, count, head.
  - Same clk/rst_n.

Test Plan:
- Boot: rst_addr=6'h04, insn_ready=1 -> first mem_rd_en at cycle 2 after release with mem_rd_addr=0x10; insn_pc sequence 0x10, 0x14, 0x18; insn_data matches RAM.
- Backpressure: insn_ready=0 from boot -> exactly 4 reads issued (0x00..0x0C), then mem_rd_en=0; insn_pc holds 0x00. Raise ready -> 4 pops in 4 cycles, fetch resumes at 0x10.
- Redirect in flight: redirect_valid with redirect_addr=6'h10 in the cycle after a read of 0x20 -> 0x20 data never appears; next insn_pc=0x40 exactly 3 cycles later; FIFO empty in between.
- Wrap: redirect to 6'h3E -> insn_pc 0xF8, 0xFC, 0x00, 0x04.
- Reset mid-run: assert rst_n=0 asynchronously while FIFO holds 3 entries -> all outputs 0 immediately (before the next clk edge); reboot from rst_addr.
- Perf (MIG1_FETCH_PERF_EN): 10 pops, 5 stall cycles, 2 redirects -> perf_fetched=10, perf_stall=5, perf_flush=2.

Source files
------------

// File: rtl/mig1_pkg.sv
// Shared types and constants for the Mig1 instruction fetch path.
package mig1_pkg;

  localparam int MIG1_ADDR_WIDTH = 8;
  localparam int MIG1_DATA_WIDTH = 32;

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} mig1_fetch_state_e;

  typedef struct packed {
    logic [MIG1_ADDR_WIDTH-1:0] pc;
    logic [MIG1_DATA_WIDTH-1:0] insn;
  } mig1_fetch_entry_t;

endpackage

// File: rtl/mig1_fetch_fifo.sv
// Prefetch buffer of (pc, insn) entries; clear wins over push/pop.
module mig1_fetch_fifo
  import mig1_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  mig1_fetch_entry_t                 push_entry,
  input  logic                              pop,
  input  logic                              clear,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH):0]       count,
  output mig1_fetch_entry_t                 head
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  mig1_fetch_entry_t mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_entry;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  // Zero the head when empty so decode never sees stale words.
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mig1_fetch_unit.sv
// Mig1 fetch stage: sequential fetch from SimRAM, prefetch FIFO, redirect flush.
// Optional perf counters under MIG1_FETCH_PERF_EN.
module mig1_fetch_unit
  import mig1_pkg::*;
#(
  parameter int ADDR_WIDTH = MIG1_ADDR_WIDTH,
  parameter int DATA_WIDTH = MIG1_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [DATA_WIDTH-1:0] insn_data,
  output logic [ADDR_WIDTH-1:0] insn_pc
`ifdef MIG1_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall,
  output logic [15:0]           perf_flush
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mig1_fetch_state_e state_q;
  logic [ADDR_WIDTH-1:0] pc_q, req_pc_q;
  logic                  inflight_q;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  redirect_acc, issue, push, pop;
  mig1_fetch_entry_t     head, push_entry;

  assign redirect_acc = redirect_valid && (state_q != BOOT);
  // Credits count the in-flight read so a capture can never overflow the FIFO.
  assign issue = (state_q == FETCH) && !redirect_valid &&
                 ((fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
  // A redirect kills the read whose data lands this cycle.
  assign push       = inflight_q && !redirect_acc;
  assign pop        = !fifo_empty && insn_ready;
  assign push_entry = '{pc: req_pc_q, insn: mem_rd_data};

  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? pc_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) req_pc_q <= pc_q;
      case (state_q)
        BOOT: begin
          pc_q    <= {rst_addr, 2'b00};
          state_q <= FETCH;
        end
        default: begin
          if (redirect_valid) begin
            pc_q    <= {redirect_addr, 2'b00};
            state_q <= FLUSH;
          end else begin
            if (state_q == FLUSH) state_q <= FETCH;
            if (issue) pc_q <= pc_q + ADDR_WIDTH'(4);
          end
        end
      endcase
    end
  end

  mig1_fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (redirect_acc),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (head)
  );

  assign insn_valid = !fifo_empty;
  assign insn_data  = head.insn;
  assign insn_pc    = head.pc;

  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full))
    else $error("fetch fifo overflow");

`ifdef MIG1_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (pop)                      perf_fetched <= perf_fetched + 32'd1;
      if (insn_valid && !insn_ready) perf_stall  <= perf_stall + 32'd1;
      if (redirect_acc)             perf_flush   <= perf_flush + 16'd1;
    end
  end
`endif

endmodule
